serial_word_receiver: RTL and testbench
=======================================

# serial_word_receiver

Front end of the serial-to-parallel converter and the producer for the 32×24-bit FIFO buffer. It synchronises an external serial link (bit clock, data, frame strobe) into the system clock domain and shifts in MSB-first 24-bit words. It then issues one write strobe per complete word into the FIFO's `write_data` / `data_in` ports. Words that arrive while the FIFO is full, and frames that end early, are dropped and reported with error pulses.

## Interface
Parameters:
- `WORD_WIDTH`, 24: bits per word; must match the FIFO data width.
- `SYNC_STAGES`, 2: flip-flop stages per input synchroniser (≥2).

Ports:
- `clock`, in, 1: system clock; single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `serial_clock`, in, 1: external bit clock, asynchronous to `clock`; frequency ≤ `clock`/4.
- `serial_data`, in, 1: serial data, valid on the `serial_clock` rising edge.
- `serial_frame`, in, 1: high for the whole of a word, sampled on the `serial_clock` rising edge.
- `full`, in, 1: FIFO full flag.
- `write_data`, out, 1: one-cycle write strobe to the FIFO.
- `parallel_data`, out, `WORD_WIDTH`: assembled word; drives FIFO `data_in`.
- `overrun_error`, out, 1: one-cycle pulse when a complete word is dropped because `full`=1.
- `frame_error`, out, 1: one-cycle pulse when a frame ends before `WORD_WIDTH` bits.

## Operation
- **Synchronisation.** `serial_clock`, `serial_data` and `serial_frame` each pass through `SYNC_STAGES` flops. One further register on synchronised `serial_clock` provides rising-edge detection, giving `bit_edge`, a one-cycle pulse. Data and frame are delayed by the same amount so that all three stay aligned.
- **Per `bit_edge`.** The synchronised data and frame values form one sample.
- **State `WAIT_LOW`** (reset state): ignore samples until a sample has frame=0, then go to `IDLE`. This guarantees that a frame already in progress when reset is released is never captured.
- **State `IDLE`:**
  - sample frame=1: shift the bit into the shift register (bit 23 first), set bit_count=1, go to `SHIFT`.
  - sample frame=0: stay in `IDLE`.
- **State `SHIFT`:**
  - sample frame=1: shift in the bit and increment bit_count. When bit_count reaches `WORD_WIDTH`, load `parallel_data` from the shift register and go to `WRITE`.
  - sample frame=0 with bit_count < `WORD_WIDTH`: pulse `frame_error`, discard the partial word, go to `IDLE`.
- **State `WRITE`** (exactly one `clock` cycle):
  - if `full`=0: `write_data`=1.
  - otherwise: `overrun_error`=1 and `write_data`=0.
  - Go to `WAIT_LOW` in both cases.
- **Extra bits.** Bits beyond `WORD_WIDTH` while frame stays high are ignored; `WAIT_LOW` absorbs them.
- **Inter-word gap.** At least one sample with frame=0 is required between words. Words are otherwise accepted back to back.
- **`parallel_data` stability.** It holds its value from `WRITE` until the next word completes. It is never modified during shifting.
- **Bit counter width.** bit_count is $clog2(`WORD_WIDTH`+1) bits wide. It never wraps, because `SHIFT` exits at `WORD_WIDTH`.

## Timing
- **Reset values.** All outputs are 0, state is `WAIT_LOW`, bit_count is 0, and the shift register and synchronisers are 0.
- **Reset mid-word.** Assertion at any time immediately discards the partial word; no write or error pulse is produced.
- **Edge detection.** `bit_edge` asserts `SYNC_STAGES`+1 `clock` cycles after a `serial_clock` rising edge at the pin.
- **Write latency.** `WRITE` (and `write_data`) occurs the cycle after the `bit_edge` of the last bit, i.e. `SYNC_STAGES`+2 cycles after the last pin edge.
- **Strobe widths.** `write_data`, `overrun_error` and `frame_error` are each exactly one cycle wide and mutually exclusive.
- **`full` sampling.** `full` is sampled only in the `WRITE` cycle. A read in the same cycle does not rescue the word, because the FIFO gives write priority over read.
- **`serial_clock` rate.** Minimum `serial_clock` high and low time is 2 `clock` cycles. Faster links are out of specification and may lose bits.

## Structure
- **Shared package `serial_rx_pkg`:**
  - `WORD_WIDTH` default constant.
  - state enumeration: `WAIT_LOW`, `IDLE`, `SHIFT`, `WRITE`.
  - bit-count width constant.
- **Sub-module `bit_synchronizer`** (parameter `SYNC_STAGES`, async-reset flop chain): instantiated three times.
- **Top level.** Edge detect, FSM, shift register and output registers live in `serial_word_receiver`.

## Test plan
- **Single word.** Frame 0xA5C3F0 MSB-first, `full`=0 → exactly one `write_data` pulse with `parallel_data`=24'hA5C3F0, no error pulses, latency `SYNC_STAGES`+2 cycles from the 24th pin edge.
- **Back to back.** Words 0x000001 and 0xFFFFFE separated by one frame-low bit → two writes in order with those values.
- **Overrun.** `full`=1 during `WRITE` for word 0x111111 → `write_data` stays 0 and one `overrun_error` pulse. The next word 0x222222 with `full`=0 is written.
- **Early frame end.** Frame drops after 10 bits → one `frame_error` pulse and no write. The following word 0x123456 is written correctly.
- **Reset mid-frame.** `reset` pulsed after 12 bits and released with frame still high → nothing written for that frame. The next full frame 0x654321 is written.
- **Long frame.** Frame held high for 30 bit edges → one write of the first 24 bits, trailing 6 bits ignored, no errors.

Source files
------------

// File: rtl/serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_pkg
// Description : Shared constants and FSM state encoding for the serial word
//               receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_rx_pkg;

  // Default word size; must match the data width of the downstream FIFO.
  localparam int WORD_WIDTH_DEFAULT = 24;

  // Width of the bit counter for the default word size (counts 0..WORD_WIDTH).
  localparam int BIT_COUNT_WIDTH = $clog2(WORD_WIDTH_DEFAULT + 1);

  // Receiver states.
  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,  // wait for a frame-low sample before accepting a word
    IDLE     = 2'd1,  // between words
    SHIFT    = 2'd2,  // collecting bits of a word
    WRITE    = 2'd3   // single cycle issuing the FIFO write (or overrun)
  } rx_state_t;

endpackage : serial_rx_pkg
`default_nettype wire

// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : bit_synchronizer
// Description : Multi-stage flip-flop synchroniser bringing one asynchronous
//               input into the clock domain, with asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; oldest sample is the output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule : bit_synchronizer
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_receiver
// Description : Synchronises an external serial link (bit clock, data, frame)
//               and assembles MSB-first words, issuing one FIFO write per
//               complete word. Overruns and short frames are dropped and
//               reported with one-cycle error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int WORD_WIDTH  = WORD_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_clock,
  input  logic                  serial_data,
  input  logic                  serial_frame,
  input  logic                  full,
  output logic                  write_data,
  output logic [WORD_WIDTH-1:0] parallel_data,
  output logic                  overrun_error,
  output logic                  frame_error
);

  localparam int COUNT_WIDTH = $clog2(WORD_WIDTH + 1);

  logic serial_clock_sync;
  logic serial_data_sync;
  logic serial_frame_sync;
  logic serial_clock_prev;
  logic bit_edge;

  rx_state_t             state;
  rx_state_t             state_next;
  logic [WORD_WIDTH-1:0]  shift_reg;
  logic [WORD_WIDTH-1:0]  shift_next;
  logic [WORD_WIDTH-1:0]  shifted;
  logic [WORD_WIDTH-1:0]  parallel_next;
  logic [COUNT_WIDTH-1:0] bit_count;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   frame_error_next;

  // All three link signals go through identical synchronisers so they stay aligned.
  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clock (
    .clock    (clock),
    .reset    (reset),
    .async_in (serial_clock),
    .sync_out (serial_clock_sync)
  );

  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clock    (clock),
    .reset    (reset),
    .async_in (serial_data),
    .sync_out (serial_data_sync)
  );

  bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_frame (
    .clock    (clock),
    .reset    (reset),
    .async_in (serial_frame),
    .sync_out (serial_frame_sync)
  );

  // Remember the previous synchronised bit clock for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      serial_clock_prev <= 1'b0;
    end else begin
      serial_clock_prev <= serial_clock_sync;
    end
  end

  assign bit_edge = serial_clock_sync & ~serial_clock_prev;

  // Shift register contents with the current sample appended as the new LSB.
  assign shifted = {shift_reg[WORD_WIDTH-2:0], serial_data_sync};

  // Next-state, datapath and strobe decode; write/overrun are decoded straight from WRITE.
  always_comb begin
    state_next       = state;
    shift_next       = shift_reg;
    count_next       = bit_count;
    parallel_next    = parallel_data;
    frame_error_next = 1'b0;
    write_data       = 1'b0;
    overrun_error    = 1'b0;

    case (state)
      WAIT_LOW: begin
        if (bit_edge && !serial_frame_sync) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (bit_edge && serial_frame_sync) begin
          shift_next = shifted;
          count_next = COUNT_WIDTH'(1);
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_edge) begin
          if (serial_frame_sync) begin
            shift_next = shifted;
            count_next = bit_count + COUNT_WIDTH'(1);
            // The bit arriving now completes the word.
            if (bit_count == COUNT_WIDTH'(WORD_WIDTH - 1)) begin
              parallel_next = shifted;
              state_next    = WRITE;
            end
          end else begin
            frame_error_next = 1'b1;
            count_next       = '0;
            state_next       = IDLE;
          end
        end
      end

      WRITE: begin
        write_data    = ~full;
        overrun_error = full;
        count_next    = '0;
        state_next    = WAIT_LOW;
      end

      default: begin
        state_next = WAIT_LOW;
        count_next = '0;
      end
    endcase
  end

  // State, datapath and registered frame-error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= WAIT_LOW;
      shift_reg     <= '0;
      bit_count     <= '0;
      parallel_data <= '0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_next;
      shift_reg     <= shift_next;
      bit_count     <= count_next;
      parallel_data <= parallel_next;
      frame_error   <= frame_error_next;
    end
  end

endmodule : serial_word_receiver
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_word_receiver
// Description : Self-checking bench for serial_word_receiver with directed
//               scenarios and randomized frames against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_receiver;

  localparam int W    = 24;
  localparam int SYNC = 2;
  localparam int HALF = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          serial_clock;
  logic          serial_data;
  logic          serial_frame;
  logic          full;
  logic          write_data;
  logic          overrun_error;
  logic          frame_error;
  logic [W-1:0]  parallel_data;

  int compared   = 0;
  int mismatched = 0;

  int cyc = 0;
  int edge_cyc = 0;
  int data_edge_cyc = 0;
  int last_wr_cyc = 0;

  // observed events
  logic [W-1:0] wr_q[$];
  int ovr_cnt = 0;
  int fe_cnt = 0;
  int excl_bad = 0;
  int width_bad = 0;
  logic prev_wr = 1'b0;
  logic prev_ovr = 1'b0;
  logic prev_fe = 1'b0;

  // model expectations
  logic [W-1:0] exp_q[$];
  int exp_ovr = 0;
  int exp_fe = 0;
  logic [W-1:0] last_word = '0;

  serial_word_receiver #(.WORD_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clock         (clock),
    .reset         (reset),
    .serial_clock  (serial_clock),
    .serial_data   (serial_data),
    .serial_frame  (serial_frame),
    .full          (full),
    .write_data    (write_data),
    .parallel_data (parallel_data),
    .overrun_error (overrun_error),
    .frame_error   (frame_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Observe strobes away from the active edge.
  always @(negedge clock) begin
    if (write_data) begin
      wr_q.push_back(parallel_data);
      last_wr_cyc = cyc;
    end
    if (overrun_error) ovr_cnt++;
    if (frame_error) fe_cnt++;
    if (int'(write_data) + int'(overrun_error) + int'(frame_error) > 1) excl_bad++;
    if ((write_data && prev_wr) || (overrun_error && prev_ovr) || (frame_error && prev_fe)) width_bad++;
    prev_wr  = write_data;
    prev_ovr = overrun_error;
    prev_fe  = frame_error;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One serial bit: data/frame set while the bit clock is low, then a rising edge.
  task automatic bit_cycle(input logic frame, input logic data);
    @(negedge clock);
    serial_frame = frame;
    serial_data  = data;
    repeat (HALF) @(negedge clock);
    serial_clock = 1'b1;
    edge_cyc = cyc;
    repeat (HALF) @(negedge clock);
    serial_clock = 1'b0;
  endtask

  // n bits MSB-first with frame high, followed by one frame-low gap bit.
  task automatic send_frame(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_cycle(1'b1, bits[i]);
    data_edge_cyc = edge_cyc;
    bit_cycle(1'b0, 1'($urandom));
    repeat (8) @(negedge clock);
  endtask

  // Frame-level model: a frame of >= W bits yields its first W bits; shorter ones are errors.
  task automatic model_frame(input logic [63:0] bits, input int n, input logic f);
    logic [63:0] tmp;
    if (n >= W) begin
      tmp = bits >> (n - W);
      if (f) exp_ovr++;
      else begin
        exp_q.push_back(tmp[W-1:0]);
        last_word = tmp[W-1:0];
      end
    end else if (n > 0) begin
      exp_fe++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".writes"}, 64'(wr_q.size()), 64'(exp_q.size()));
    while (wr_q.size() > 0 && exp_q.size() > 0)
      check({tag, ".data"}, 64'(wr_q.pop_front()), 64'(exp_q.pop_front()));
    wr_q.delete();
    exp_q.delete();
    check({tag, ".overrun"}, 64'(ovr_cnt), 64'(exp_ovr));
    check({tag, ".frame_err"}, 64'(fe_cnt), 64'(exp_fe));
  endtask

  task automatic do_frame(input string tag, input logic [63:0] bits, input int n, input logic f);
    @(negedge clock);
    full = f;
    model_frame(bits, n, f);
    send_frame(bits, n);
    compare_all(tag);
  endtask

  initial begin
    logic [63:0] bits;
    int n;
    logic f;

    reset = 1'b1;
    serial_clock = 1'b0;
    serial_data = 1'b0;
    serial_frame = 1'b0;
    full = 1'b0;
    repeat (3) @(negedge clock);
    check("rst.write_data", 64'(write_data), 64'd0);
    check("rst.overrun", 64'(overrun_error), 64'd0);
    check("rst.frame_err", 64'(frame_error), 64'd0);
    check("rst.parallel", 64'(parallel_data), 64'd0);
    reset = 1'b0;

    // leave WAIT_LOW
    bit_cycle(1'b0, 1'b0);
    repeat (4) @(negedge clock);

    do_frame("single", 64'hA5C3F0, 24, 1'b0);
    check("single.latency", 64'(last_wr_cyc + 1 - data_edge_cyc), 64'(SYNC + 2));

    do_frame("b2b_a", 64'h000001, 24, 1'b0);
    do_frame("b2b_b", 64'hFFFFFE, 24, 1'b0);

    do_frame("overrun", 64'h111111, 24, 1'b1);
    do_frame("after_ovr", 64'h222222, 24, 1'b0);

    do_frame("early", 64'h2AB, 10, 1'b0);
    check("early.hold", 64'(parallel_data), 64'(last_word));
    do_frame("after_early", 64'h123456, 24, 1'b0);

    // reset after 12 bits, released with frame still high
    bits = 64'h654321;
    for (int i = 23; i >= 12; i--) bit_cycle(1'b1, bits[i]);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    last_word = '0;
    check("midrst.parallel", 64'(parallel_data), 64'd0);
    for (int i = 11; i >= 0; i--) bit_cycle(1'b1, bits[i]);
    bit_cycle(1'b0, 1'b0);
    repeat (8) @(negedge clock);
    compare_all("midrst");
    do_frame("after_rst", 64'h654321, 24, 1'b0);

    bits = {32'($urandom), 32'($urandom)};
    do_frame("long", bits, 30, 1'b0);

    for (int k = 0; k < 16; k++) begin
      int sel;
      bits = {32'($urandom), 32'($urandom)};
      sel = int'($urandom_range(0, 99));
      if (sel < 70) n = W;
      else if (sel < 85) n = int'($urandom_range(1, W - 1));
      else n = int'($urandom_range(W + 1, 30));
      f = ($urandom_range(0, 3) == 0);
      do_frame($sformatf("rand%0d", k), bits, n, f);
    end

    check("exclusive", 64'(excl_bad), 64'd0);
    check("strobe_width", 64'(width_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_serial_word_receiver
`default_nettype wire
